// File: rtl/ubin_pkg.sv
// Shared types and helpers for the unary-to-binary window accumulator.
// The helpers are also used by the bench model.
package ubin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned BITWIDTH_DEF = 8;

    // Window length 2^bw in samples.
    function automatic logic [31:0] win_len(input int unsigned bw);
        return 32'(1) << bw;
    endfunction

    // Bipolar value 2*count - 2^bw, two's complement in 32 bits.
    function automatic logic [31:0] bipolar(input logic [31:0] count, input int unsigned bw);
        return (count << 1) - win_len(bw);
    endfunction

endpackage

// File: rtl/ubin_win_cnt.sv
// Window sample counter: BITWIDTH-bit wrapping counter with clear, enable and
// a terminal-count flag raised on the last sample of the window.
module ubin_win_cnt
    import ubin_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam logic [BITWIDTH-1:0] LAST = BITWIDTH'(win_len(BITWIDTH) - 32'd1);

    logic [BITWIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + BITWIDTH'(1);
        end
    end

    assign tc_c = en && (cnt == LAST);

endmodule

// File: rtl/ubin_acc.sv
// Counts ones of a unary stream over 2^BITWIDTH samples and hands the count
// out over valid/ready. Define UBIN_ACC_BIPOLAR_EN for a bipolar result.
module ubin_acc
    import ubin_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH:0]   out_data
);

    localparam int unsigned DW = BITWIDTH + 1;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   data_d;
    logic            valid_d;
    logic            busy_d;
    logic [DW-1:0]   sum_c;
    logic [DW-1:0]   result_c;
    logic            cnt_clr;
    logic            cnt_en;
    logic            tc_c;

    assign cnt_clr = (state_q == IDLE) && start;
    assign cnt_en  = (state_q == ACC);
    assign sum_c   = acc_q + DW'(in);

    // The last sample is folded in directly so the final count needs no extra cycle.
`ifdef UBIN_ACC_BIPOLAR_EN
    assign result_c = DW'(bipolar(32'(sum_c), BITWIDTH));
`else
    assign result_c = sum_c;
`endif

    ubin_win_cnt #(
        .BITWIDTH (BITWIDTH)
    ) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clr),
        .en    (cnt_en),
        .tc_c  (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        data_d  = out_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = sum_c;
                if (tc_c) begin
                    data_d  = result_c;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ubin_acc.sv
// Scoreboard bench for ubin_acc with BITWIDTH=4 (16-sample window).
module tb_ubin_acc;
    import ubin_pkg::*;

    localparam int unsigned BW = 4;
    localparam int unsigned DW = BW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int            total = 0;
    int            bad = 0;
    int            rx_cnt = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ubin_acc #(.BITWIDTH(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_val(input int unsigned count);
`ifdef UBIN_ACC_BIPOLAR_EN
        return DW'(bipolar(32'(count), BW));
`else
        return DW'(count);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is consumed at the edge after valid&ready is seen here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result: got %0h with no result expected at %0t", out_data, $time);
            end else begin
                check("result", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_window(input logic [15:0] pat, input int unsigned ones,
                              input logic pre_in, input bit poke_start);
        start = 1'b1;
        in    = pre_in;
        exp_q.push_back(exp_val(ones));
        step();
        start = 1'b0;
        check("busy_acc", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            in    = pat[i];
            start = poke_start && (i == 5);
            if (i == 15) check("valid_before_end", 32'(out_valid), 32'd0);
            step();
        end
        in    = 1'b0;
        start = 1'b0;
        check("valid_latency", 32'(out_valid), 32'd1);
        check("busy_hold", 32'(busy), 32'd1);
    endtask

    task automatic accept(input int unsigned ones, input int unsigned hold, input bit poke_start);
        out_ready = 1'b0;
        for (int i = 0; i < int'(hold); i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_val(ones)));
            check("hold_busy", 32'(busy), 32'd1);
            start = poke_start && (i == 2);
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic counts, alternating pattern, start-cycle sample excluded.
        run_window(16'hFFFF, 16, 1'b0, 1'b0);
        accept(16, 0, 1'b0);
        run_window(16'h0000, 0, 1'b0, 1'b0);
        accept(0, 0, 1'b0);
        run_window(16'h5555, 8, 1'b0, 1'b0);
        accept(8, 0, 1'b0);
        run_window(16'h0000, 0, 1'b1, 1'b0);
        accept(0, 0, 1'b0);

        // Backpressure with start pokes in ACC and HOLD.
        run_window(16'h0FFF, 12, 1'b0, 1'b1);
        accept(12, 5, 1'b1);
        step();
        check("no_extra_busy", 32'(busy), 32'd0);
        check("no_extra_valid", 32'(out_valid), 32'd0);

        // Back-to-back windows at minimum gap.
        run_window(16'hFFFF, 16, 1'b0, 1'b0);
        accept(16, 0, 1'b0);
        run_window(16'h0007, 3, 1'b0, 1'b0);
        accept(3, 0, 1'b0);

        // Reset after 7 ones, mid-cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        in    = 1'b1;
        for (int i = 0; i < 7; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        in = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_window(16'h0000, 0, 1'b0, 1'b0);
        accept(0, 0, 1'b0);

        step();
        check("results_seen", 32'(rx_cnt), 32'd8);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
